gf12_sram_banked_arb: RTL and testbench

Parametrised one-write/one-read banked memory wrapper built from GF12 single-port SRAM macros (GF12_SRAM_SP_<2^BANK_ABITS>x<DATA_WIDTH>_HD), one macro per bank. It generalises the fixed 64-bit, 4-bank, 15-address-bit wrapper in width, depth and bank count. Same-bank port conflicts are arbitrated in hardware with per-port ready handshakes, where the fixed wrapper lets the read silently override the write. It adds a registered read-valid strobe, a held read output and a saturating stall counter. It sits between ESP accelerator private-local-memory (PLM) controllers and the SRAM macros.

---
 rtl/gf12_sram_banked_arb.sv | 148 ++++++++++++++
 tb/tb_gf12_sram_banked_arb.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/gf12_sram_banked_arb.sv
// Banked one-write/one-read memory wrapper over single-port SRAM macros, with same-bank
// conflict arbitration, a read-valid strobe, held read data and a saturating conflict counter.

module gf12_sram_sp_hd #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ABITS      = 13
) (
  input  logic                  clk_i,
  input  logic                  ce_i,
  input  logic                  we_i,
  input  logic [ABITS-1:0]      a_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  input  logic [DATA_WIDTH-1:0] wem_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  localparam int unsigned DEPTH = 1 << ABITS;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Behavioural stand-in for the single-port macro: bit-masked write, registered read.
  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      if (we_i) mem_q[a_i] <= (mem_q[a_i] & ~wem_i) | (d_i & wem_i);
      else      q_o        <= mem_q[a_i];
    end
  end
endmodule

module gf12_sram_banked_arb #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_BITS  = 15,
  parameter int unsigned BANK_ABITS = 13,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce0_i,
  input  logic [ADDR_BITS-1:0]  a0_i,
  input  logic [DATA_WIDTH-1:0] d0_i,
  input  logic                  we0_i,
  input  logic [DATA_WIDTH-1:0] wem0_i,
  output logic                  rdy0_o,
  input  logic                  ce1_i,
  input  logic [ADDR_BITS-1:0]  a1_i,
  output logic                  rdy1_o,
  output logic [DATA_WIDTH-1:0] q1_o,
  output logic                  qv1_o,
  output logic [15:0]           stalls_o
);
  localparam int unsigned NBANKS  = 1 << (ADDR_BITS - BANK_ABITS);
  localparam int unsigned BW      = (NBANKS > 1) ? ADDR_BITS - BANK_ABITS : 1;
  localparam int unsigned STALL_W = 16;
  localparam logic        LOSER_RD = 1'b0;
  localparam logic        LOSER_WR = 1'b1;

  logic [BW-1:0]         bank0, bank1, sel_q, sel_d;
  logic [BANK_ABITS-1:0] off0, off1;
  logic                  same_bank, conflict, read_wins, wr_acc, rd_acc;
  logic                  last_loser_q, last_loser_d;
  logic                  qv1_q, qv1_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, rd_data;
  logic [STALL_W-1:0]    stalls_q, stalls_d;
  logic [DATA_WIDTH-1:0] bank_q [NBANKS];

  assign bank0     = BW'(a0_i >> BANK_ABITS);
  assign bank1     = BW'(a1_i >> BANK_ABITS);
  assign off0      = a0_i[BANK_ABITS-1:0];
  assign off1      = a1_i[BANK_ABITS-1:0];
  assign same_bank = (NBANKS > 1) && (bank0 == bank1);

  // A write with WE0 low never touches a bank, so it cannot conflict.
  assign conflict  = ce0_i & we0_i & ce1_i & same_bank;
  assign read_wins = conflict & (ARB_MODE == 1) & (last_loser_q == LOSER_RD);
  assign rdy0_o    = ~rst_i & ~read_wins;
  assign rdy1_o    = ~rst_i & ~(conflict & ~read_wins);
  assign wr_acc    = ce0_i & rdy0_o;
  assign rd_acc    = ce1_i & rdy1_o;

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic                  wr_sel, rd_sel, ce, we;
    logic [BANK_ABITS-1:0] a;
    logic [DATA_WIDTH-1:0] d, wem;

    // Per-bank drive; an unselected bank sees all-zero inputs.
    always_comb begin
      wr_sel = wr_acc & we0_i & (bank0 == BW'(b));
      rd_sel = rd_acc & (bank1 == BW'(b));
      ce     = wr_sel | rd_sel;
      we     = wr_sel;
      a      = wr_sel ? off0 : (rd_sel ? off1 : '0);
      d      = wr_sel ? d0_i : '0;
      wem    = wr_sel ? wem0_i : '0;
    end

    gf12_sram_sp_hd #(
      .DATA_WIDTH (DATA_WIDTH),
      .ABITS      (BANK_ABITS)
    ) u_sram (
      .clk_i (clk_i),
      .ce_i  (ce),
      .we_i  (we),
      .a_i   (a),
      .d_i   (d),
      .wem_i (wem),
      .q_o   (bank_q[b])
    );
  end

  if (NBANKS > 1) begin : g_rdmux
    assign rd_data = bank_q[sel_q];
  end else begin : g_rdone
    assign rd_data = bank_q[0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q        <= '0;
      qv1_q        <= 1'b0;
      hold_q       <= '0;
      last_loser_q <= LOSER_RD;
      stalls_q     <= '0;
    end else begin
      sel_q        <= sel_d;
      qv1_q        <= qv1_d;
      hold_q       <= hold_d;
      last_loser_q <= last_loser_d;
      stalls_q     <= stalls_d;
    end
  end

  always_comb begin
    sel_d        = sel_q;
    qv1_d        = rd_acc;
    hold_d       = hold_q;
    last_loser_d = last_loser_q;
    stalls_d     = stalls_q;
    if (rd_acc) sel_d = bank1;
    if (qv1_q)  hold_d = rd_data;
    if (conflict) begin
      last_loser_d = read_wins ? LOSER_WR : LOSER_RD;
      if (stalls_q != '1) stalls_d = stalls_q + STALL_W'(1);
    end
  end

  assign q1_o     = qv1_q ? rd_data : hold_q;
  assign qv1_o    = qv1_q;
  assign stalls_o = stalls_q;
endmodule

// File: tb/tb_gf12_sram_banked_arb.sv
// Directed vector bench for gf12_sram_banked_arb: one instance per arbitration mode.
module tb_gf12_sram_banked_arb;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DEAD   = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] PAT    = 64'h1111_2222_3333_4444;
  localparam logic [63:0] A5     = 64'hA5A5_A5A5_5A5A_5A5A;
  localparam logic [63:0] HIMASK = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] LOMASK = 64'h0000_0000_FFFF_FFFF;
  localparam int NV = 18;

  typedef struct {
    logic        ce0, we0;
    logic [14:0] a0;
    logic [63:0] d0, wem0;
    logic        ce1;
    logic [14:0] a1;
    logic        rdy0, rdy1, qv1, chk_q;
    logic [63:0] q1;
    logic [15:0] stalls;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        ce0 = 1'b0, we0 = 1'b0, ce1 = 1'b0;
  logic        ce0_m1 = 1'b0, ce1_m1 = 1'b0;
  logic [14:0] a0 = '0, a1 = '0;
  logic [63:0] d0 = '0, wem0 = '0;
  logic        rdy0, rdy1, qv1, rdy0_m1, rdy1_m1, qv1_m1;
  logic [63:0] q1, q1_m1;
  logic [15:0] stalls, stalls_m1;

  int n_vec = 0, n_bad = 0;
  vec_t vt [NV];

  always #5 clk = ~clk;

  gf12_sram_banked_arb #(.ARB_MODE(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .ce0_i(ce0), .a0_i(a0), .d0_i(d0), .we0_i(we0), .wem0_i(wem0),
    .rdy0_o(rdy0), .ce1_i(ce1), .a1_i(a1), .rdy1_o(rdy1), .q1_o(q1), .qv1_o(qv1),
    .stalls_o(stalls));

  gf12_sram_banked_arb #(.ARB_MODE(1)) u_dut_m1 (
    .clk_i(clk), .rst_i(rst), .ce0_i(ce0_m1), .a0_i(a0), .d0_i(d0), .we0_i(we0), .wem0_i(wem0),
    .rdy0_o(rdy0_m1), .ce1_i(ce1_m1), .a1_i(a1), .rdy1_o(rdy1_m1), .q1_o(q1_m1), .qv1_o(qv1_m1),
    .stalls_o(stalls_m1));

  function automatic vec_t mk(input logic c0, w0, input logic [14:0] ad0, input logic [63:0] dd,
                              input logic [63:0] wm, input logic c1, input logic [14:0] ad1,
                              input logic r0, r1, qv, cq, input logic [63:0] q,
                              input logic [15:0] st);
    vec_t v;
    v.ce0 = c0; v.we0 = w0; v.a0 = ad0; v.d0 = dd; v.wem0 = wm; v.ce1 = c1; v.a1 = ad1;
    v.rdy0 = r0; v.rdy1 = r1; v.qv1 = qv; v.chk_q = cq; v.q1 = q; v.stalls = st;
    return v;
  endfunction

  task automatic drive(input logic c0, w0, input logic [14:0] ad0, input logic [63:0] dd,
                       input logic [63:0] wm, input logic c1, input logic [14:0] ad1);
    ce0 = c0; we0 = w0; a0 = ad0; d0 = dd; wem0 = wm; ce1 = c1; a1 = ad1;
  endtask

  task automatic check(input string name, input logic ar0, ar1, aqv, input logic [63:0] aq,
                       input logic [15:0] ast, input logic er0, er1, eqv, cq,
                       input logic [63:0] eq, input logic [15:0] est);
    n_vec++;
    if (ar0 !== er0 || ar1 !== er1 || aqv !== eqv || (cq && aq !== eq) || ast !== est) begin
      n_bad++;
      $display("FAIL %s: got rdy0=%b rdy1=%b qv1=%b q1=%h stalls=%0d; want rdy0=%b rdy1=%b qv1=%b q1=%h%s stalls=%0d",
               name, ar0, ar1, aqv, aq, ast, er0, er1, eqv, eq, cq ? "" : "(ignored)", est);
    end
  endtask

  task automatic check0(input string name, input logic er0, er1, eqv, cq,
                        input logic [63:0] eq, input logic [15:0] est);
    check(name, rdy0, rdy1, qv1, q1, stalls, er0, er1, eqv, cq, eq, est);
  endtask

  initial begin
    logic rd_turn, prev_rd;

    vt[0]  = mk(1, 1, 15'h2005, PAT,    ONES,   0, 15'h0000, 1, 1, 0, 1, 64'h0, 0);
    vt[1]  = mk(1, 1, 15'h0005, DEAD,   ONES,   1, 15'h2005, 1, 1, 0, 1, 64'h0, 0);
    vt[2]  = mk(0, 0, 15'h0000, 64'h0,  64'h0,  1, 15'h0005, 1, 1, 1, 1, PAT, 0);
    vt[3]  = mk(0, 0, 15'h0000, 64'h0,  64'h0,  0, 15'h0000, 1, 1, 1, 1, DEAD, 0);
    vt[4]  = mk(0, 0, 15'h0000, 64'h0,  64'h0,  0, 15'h0000, 1, 1, 0, 1, DEAD, 0);
    vt[5]  = mk(1, 1, 15'h7FFF, ONES,   ONES,   0, 15'h0000, 1, 1, 0, 1, DEAD, 0);
    vt[6]  = mk(1, 1, 15'h7FFF, 64'h0,  LOMASK, 0, 15'h0000, 1, 1, 0, 1, DEAD, 0);
    vt[7]  = mk(0, 0, 15'h0000, 64'h0,  64'h0,  1, 15'h7FFF, 1, 1, 0, 1, DEAD, 0);
    vt[8]  = mk(1, 0, 15'h7FFF, 64'h1234, ONES, 1, 15'h7FFF, 1, 1, 1, 1, HIMASK, 0);
    vt[9]  = mk(0, 0, 15'h0000, 64'h0,  64'h0,  0, 15'h0000, 1, 1, 1, 1, HIMASK, 0);
    vt[10] = mk(1, 1, 15'h6010, A5,     ONES,   1, 15'h6010, 1, 0, 0, 1, HIMASK, 0);
    vt[11] = mk(1, 1, 15'h6010, A5,     ONES,   1, 15'h6010, 1, 0, 0, 1, HIMASK, 1);
    vt[12] = mk(1, 1, 15'h6010, A5,     ONES,   1, 15'h6010, 1, 0, 0, 1, HIMASK, 2);
    vt[13] = mk(0, 0, 15'h0000, 64'h0,  64'h0,  1, 15'h6010, 1, 1, 0, 1, HIMASK, 3);
    vt[14] = mk(0, 0, 15'h0000, 64'h0,  64'h0,  1, 15'h0005, 1, 1, 1, 1, A5, 3);
    vt[15] = mk(0, 0, 15'h0000, 64'h0,  64'h0,  1, 15'h7FFF, 1, 1, 1, 1, DEAD, 3);
    vt[16] = mk(0, 0, 15'h0000, 64'h0,  64'h0,  0, 15'h0000, 1, 1, 1, 1, HIMASK, 3);
    vt[17] = mk(0, 0, 15'h0000, 64'h0,  64'h0,  0, 15'h0000, 1, 1, 0, 1, HIMASK, 3);

    // Power-on reset with requests pending: ready stays low, outputs cleared.
    @(negedge clk);
    drive(1, 1, 15'h0005, ONES, ONES, 1, 15'h0005);
    #1 check0("por", 0, 0, 0, 1, 64'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 15'h0000, 64'h0, 64'h0, 0, 15'h0000);
    #1 check0("por_release", 1, 1, 0, 1, 64'h0, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].ce0, vt[i].we0, vt[i].a0, vt[i].d0, vt[i].wem0, vt[i].ce1, vt[i].a1);
      #1 check0($sformatf("vec%0d", i), vt[i].rdy0, vt[i].rdy1, vt[i].qv1, vt[i].chk_q,
                vt[i].q1, vt[i].stalls);
    end

    // Alternating arbitration: continuous same-bank traffic, first conflict goes to the read.
    rd_turn = 1'b1;
    prev_rd = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(0, 1, 15'h6020, A5, ONES, 0, 15'h6021);
      ce0_m1 = 1'b1; ce1_m1 = 1'b1;
      #1 check($sformatf("alt%0d", k), rdy0_m1, rdy1_m1, qv1_m1, q1_m1, stalls_m1,
               ~rd_turn, rd_turn, prev_rd, 1'b0, 64'h0, 16'(k));
      prev_rd = rd_turn;
      rd_turn = ~rd_turn;
    end
    @(negedge clk);
    ce0_m1 = 1'b0; ce1_m1 = 1'b0;
    #1 check("alt_end", rdy0_m1, rdy1_m1, qv1_m1, q1_m1, stalls_m1,
             1, 1, prev_rd, 1'b0, 64'h0, 6);

    // Reset asserted asynchronously while a read is being presented.
    @(negedge clk);
    drive(0, 0, 15'h0000, 64'h0, 64'h0, 1, 15'h0005);
    #1 check0("pre_rst_read", 1, 1, 0, 1, HIMASK, 3);
    #2 rst = 1'b1;
    #1 check0("rst_async", 0, 0, 0, 1, 64'h0, 0);
    check("rst_async_m1", rdy0_m1, rdy1_m1, qv1_m1, q1_m1, stalls_m1, 0, 0, 0, 1, 64'h0, 0);
    @(negedge clk);
    #1 check0("rst_held", 0, 0, 0, 1, 64'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 15'h0000, 64'h0, 64'h0, 0, 15'h0000);
    #1 check0("rst_release", 1, 1, 0, 1, 64'h0, 0);
    @(negedge clk);
    #1 check0("rst_no_qv", 1, 1, 0, 1, 64'h0, 0);

    // Saturation: 65540 conflict cycles with the read starved, then hold for 10 idle cycles.
    @(negedge clk);
    drive(0, 0, 15'h0000, 64'h0, 64'h0, 1, 15'h0005);
    #1 check0("sat_pre_read", 1, 1, 0, 1, 64'h0, 0);
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      drive(1, 1, 15'h0100, 64'h0, ONES, 1, 15'h0006);
      #1;
      if (i == 0)     check0("sat_start", 1, 0, 1, 1, DEAD, 0);
      if (i == 65535) check0("sat_reach", 1, 0, 0, 1, DEAD, 16'hFFFF);
      if (i == 65539) check0("sat_hold", 1, 0, 0, 1, DEAD, 16'hFFFF);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(0, 0, 15'h0000, 64'h0, 64'h0, 0, 15'h0000);
      #1 check0($sformatf("idle_hold%0d", i), 1, 1, 0, 1, DEAD, 16'hFFFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
